// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || (addr >= 32'(4 * depth));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/en_rst_flop.sv
// Enabled register with asynchronous active-low reset to zero.
// Loads d_i on any clock edge where en_i is high; otherwise holds.
module en_rst_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_word_ram.sv
// DEPTH x 32 word store: synchronous byte-lane write, combinational read.
// Contents are deliberately not reset.
module mem_word_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: response WAIT+1 cycles after accept.
// Accepts only in IDLE; response held stable until rsp_ready, then one IDLE cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  req_t              req_in, req_q, cur;
  logic              accept, commit, cur_err, ram_we;
  logic [AW-1:0]     word_idx;
  logic [31:0]       ram_rdata;

  assign req_in = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};

  assign bus.req_ready = (state_q == IDLE);
  assign accept        = bus.req_valid & bus.req_ready;

  en_rst_flop #(.W($bits(req_t))) u_req_flop (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (accept),
    .d_i   (req_in),
    .q_o   (req_q)
  );

  // With WAIT=0 the commit edge is the accept edge, so the live request is used.
  assign cur      = (state_q == IDLE) ? req_in : req_q;
  assign cur_err  = addr_err(cur.addr, DEPTH);
  assign word_idx = cur.addr[AW+1:2];
  assign ram_we   = commit & reset & cur.we & ~cur_err;

  mem_word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (cur.be),
    .addr_i  (word_idx),
    .wdata_i (cur.wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CNT_W'(WAIT);
          if (WAIT > 0) begin
            state_d = mem_responder_pkg::WAIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      mem_responder_pkg::WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rsp_err_d   = cur_err;
      rsp_rdata_d = (cur_err || cur.we) ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT=2 and a WAIT=0 instance.
module tb_mem_responder;

  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if bus_a();
  mem_responder_if bus_b();

  mem_responder #(.DEPTH(64), .WAIT(WAIT_A)) dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
  mem_responder #(.DEPTH(64), .WAIT(WAIT_B)) dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.rsp_valid === 1'b1 && bus_a.rsp_ready === 1'b1) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_rsp: got rdata %08h with no expected entry", bus_a.rsp_rdata);
      end else begin
        e = qa.pop_front();
        chk("a_rsp_rdata", bus_a.rsp_rdata, e.rdata);
        chk("a_rsp_err", {31'b0, bus_a.rsp_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.rsp_valid === 1'b1 && bus_b.rsp_ready === 1'b1) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_rsp: got rdata %08h with no expected entry", bus_b.rsp_rdata);
      end else begin
        e = qb.pop_front();
        chk("b_rsp_rdata", bus_b.rsp_rdata, e.rdata);
        chk("b_rsp_err", {31'b0, bus_b.rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 one edge after rsp_valid is first seen.
  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                         input string name);
    int   n;
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    qa.push_back(e);
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_be    = be;
    bus_a.req_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus_a.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: req_ready stuck at %b", name, bus_a.req_ready);
    end
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus_a.rsp_valid === 1'b1) break;
    end
    chk({name, "_latency"}, n, WAIT_A + 1);
    @(posedge clk);
    #1;
  endtask

  int accc[2];
  int rspc[2];
  int na, nr;
  logic pend;
  exp_t eb;

  initial begin
    rst_n = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_be = '0;   bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_be = '0;   bus_b.rsp_ready = 1'b1;
    #2;
    chk("rst_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, bus_a.rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    chk("rst_b_rsp_valid", {31'b0, bus_b.rsp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st10");
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10");
    issue_a(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "st20a");
    issue_a(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, "st20b");
    issue_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "ld20");
    issue_a(1'b1, 32'h24, 32'h55667788, 4'hF, 32'h0, 1'b0, "st24");
    issue_a(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, "st24_be0");
    issue_a(1'b0, 32'h24, 32'h0, 4'h0, 32'h55667788, 1'b0, "ld24");
    issue_a(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, "ld22_mis");
    issue_a(1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1, "ld100_oor");
    issue_a(1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, "st00");
    issue_a(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st100_oor");
    issue_a(1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st21_mis");
    issue_a(1'b0, 32'h0, 32'h0, 4'h0, 32'h01020304, 1'b0, "ld00");
    issue_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "ld20_again");

    // Backpressure: response must hold while rsp_ready is low.
    bus_a.rsp_ready = 1'b0;
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10_hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", bus_a.rsp_rdata, 32'hDEADBEEF);
      chk("hold_req_ready", {31'b0, bus_a.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus_a.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("release_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-WAIT aborts the store.
    issue_a(1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0, "st30");
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10_pre");
    bus_a.req_we = 1'b1; bus_a.req_addr = 32'h30; bus_a.req_wdata = 32'hFFFFFFFF;
    bus_a.req_be = 4'hF; bus_a.req_valid = 1'b1;
    @(negedge clk);
    chk("abort_ready_before", {31'b0, bus_a.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", {31'b0, bus_a.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    chk("abort_rsp_err", {31'b0, bus_a.rsp_err}, 32'd0);
    chk("abort_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue_a(1'b0, 32'h30, 32'h0, 4'h0, 32'h12345678, 1'b0, "ld30_after_rst");

    // WAIT=0 instance: back-to-back requests with req_valid held high.
    eb.rdata = 32'h0;        eb.err = 1'b0; qb.push_back(eb);
    eb.rdata = 32'hCAFEF00D; eb.err = 1'b0; qb.push_back(eb);
    bus_b.req_we = 1'b1; bus_b.req_addr = 32'h04; bus_b.req_wdata = 32'hCAFEF00D;
    bus_b.req_be = 4'hF; bus_b.req_valid = 1'b1;
    na = 0; nr = 0; pend = 1'b0;
    accc[0] = 0; accc[1] = 0; rspc[0] = 0; rspc[1] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_b.rsp_valid === 1'b1 && nr < 2) begin
        rspc[nr] = c;
        nr++;
      end
      if (pend) begin
        pend = 1'b0;
        if (na == 1) begin
          bus_b.req_we = 1'b0; bus_b.req_addr = 32'h04;
          bus_b.req_wdata = 32'h0; bus_b.req_be = 4'h0;
        end else begin
          bus_b.req_valid = 1'b0;
        end
      end
      if (bus_b.req_valid === 1'b1 && bus_b.req_ready === 1'b1 && na < 2) begin
        accc[na] = c;
        na++;
        pend = 1'b1;
      end
    end
    chk("b_accept_count", na, 32'd2);
    chk("b_rsp_count", nr, 32'd2);
    chk("b_accept_spacing", accc[1] - accc[0], 32'd2);
    chk("b_latency_store", rspc[0] - accc[0], WAIT_B + 1);
    chk("b_latency_load", rspc[1] - accc[1], WAIT_B + 1);

    repeat (2) @(posedge clk);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words stored (power of two, 4..1024).
REQ-002 Parameter WAIT, default 2, wait-state cycles between request acceptance and response (0..15).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req_valid  in  1  initiator presents a request.
REQ-006 req_ready  out  1  responder accepts a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 req_be  in  4  byte enables for store; bit i selects byte lane [8i+7:8i].
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  initiator consumes the response.
REQ-013 rsp_rdata  out  32  load data; 0 for stores and for errors.
REQ-014 rsp_err  out  1  request was misaligned or out of range.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; on accept, we/addr/wdata/be SHALL be captured and the wait counter loaded with WAIT.
REQ-017 From IDLE on accept: go to WAIT if WAIT>0, else to RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle; the cycle it reaches 1, next state is RESP.
REQ-019 rsp_valid SHALL rise exactly WAIT+1 cycles after the accept edge and equal 1 only in RESP.
REQ-020 Word index = captured addr[log2(DEPTH)+1:2]; error = addr[1:0]!=0 or addr >= 4*DEPTH.
REQ-021 On the edge entering RESP: non-error store writes only enabled byte lanes; non-error load latches the word into rsp_rdata; error latches rsp_err=1, rsp_rdata=0, no memory change.
REQ-022 rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 RESP with rsp_ready=1: return to IDLE next cycle, rsp_valid drops; no request accepted in that same cycle.
REQ-024 Store with req_be=0 SHALL complete normally (rsp_err=0) without modifying memory.
REQ-025 Inputs other than rsp_ready are ignored outside IDLE; req_valid deassertion mid-transaction has no effect.

Reset
REQ-026 reset=0 SHALL force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, captured request 0, immediately.
REQ-027 Memory array contents SHALL NOT be reset; reads of never-written words return undefined data.
REQ-028 Reset asserted before the commit edge of REQ-021 SHALL abort the transaction with no memory write.

Structure
REQ-029 Package mem_responder_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the counter width constant (4).
REQ-030 Storage SHALL be one sub-module mem_word_ram (DEPTH x 32, byte-lane write enable, synchronous write, combinational read).
REQ-031 Request capture register SHALL use the team's enabled-reset flop with async active-low reset.

Verification
REQ-032 WAIT=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF, rsp_ready=1 -> rsp_valid high 3 cycles after accept, rsp_err=0; then load 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-033 Store 0x11223344 to 0x20 be 0xF, then store 0xAABBCCDD be 0x5 -> load 0x20 returns 0x11BB33DD.
REQ-034 Load addr 0x22 (misaligned) and addr 4*DEPTH (0x100) -> rsp_err=1, rsp_rdata 0, memory unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-036 WAIT=0 build: accept -> rsp_valid next cycle; back-to-back requests with req_valid held 1 -> accepts every 2 cycles minimum.
REQ-037 Assert reset during WAIT of a store to 0x30 -> outputs zero immediately, later load 0x30 returns prior contents.
